// File: rtl/stage_one.sv
// -----------------------------------------------------------------------------
// stage_one
//   First stage of the TMDS 8b/10b encoder. It turns a pixel byte D[7:0] into
//   the 9-bit transition-minimised word q_m[8:0]:
//     - It uses an XOR chain or an XNOR chain, whichever gives fewer transitions.
//     - q_m[8] records the chain: 1 means XOR, 0 means XNOR.
//   It also holds a registered copy of q_m and the popcount of q_m[7:0]. The
//   DC-balancing second stage reads these.
//
// Ports
//   clk          in   rising-edge clock
//   n_rst        in   asynchronous reset, active low
//   st1_in       in   [7:0] data byte D
//   st1_en       in   capture the current encoding at the next rising edge
//   st1_out      out  [8:0] combinational q_m of st1_in (zero latency)
//   st1_out_reg  out  [8:0] registered q_m
//   st1_ones_reg out  [3:0] registered popcount of q_m[7:0] (0..8)
//   st1_valid    out  high in the cycle after st1_en was sampled high
// -----------------------------------------------------------------------------
module stage_one (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] st1_in,
  input  logic       st1_en,
  output logic [8:0] st1_out,
  output logic [8:0] st1_out_reg,
  output logic [3:0] st1_ones_reg,
  output logic       st1_valid
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] q_m;
  logic [3:0] q_ones;

  // Count the ones in the input byte. The result fits in 4 bits, so it
  // cannot wrap.
  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1 = n1 + {3'b000, st1_in[i]};
    end
  end

  // Use the XNOR chain when the byte is dense in ones.
  // When the count is exactly 4, D[0] decides which chain to use.
  assign use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !st1_in[0]);

  // The chain q_m[i] = q_m[i-1] op D[i] is written in closed form here:
  //   - q_m[i] is the XOR of D[0..i].
  //   - In XNOR mode, every odd position gets one extra inversion relative
  //     to XOR mode (the inversions cancel in pairs).
  // This keeps each bit independent instead of building a long ripple of
  // bits that depend on each other.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_qm
      localparam logic ODD_POS = ((gi % 2) == 1);
      assign q_m[gi] = (^st1_in[gi:0]) ^ (use_xnor & ODD_POS);
    end
  endgenerate

  assign q_m[8]  = ~use_xnor;
  assign st1_out = q_m;

  // Popcount of the encoded data bits. Stage two needs this value.
  always_comb begin
    q_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      q_ones = q_ones + {3'b000, q_m[i]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st1_out_reg  <= 9'h000;
      st1_ones_reg <= 4'd0;
      st1_valid    <= 1'b0;
    end else begin
      st1_valid <= st1_en;
      if (st1_en) begin
        st1_out_reg  <= q_m;
        st1_ones_reg <= q_ones;
      end
    end
  end

endmodule

// File: tb/tb_stage_one.sv
module tb_stage_one;

  logic       clk;
  logic       n_rst;
  logic [7:0] st1_in;
  logic       st1_en;
  logic [8:0] st1_out;
  logic [8:0] st1_out_reg;
  logic [3:0] st1_ones_reg;
  logic       st1_valid;

  int checks;
  int failures;

  // Reference copy of the registered outputs.
  logic [8:0] exp_out_reg;
  logic [3:0] exp_ones;
  logic       exp_valid;

  stage_one dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .st1_in      (st1_in),
    .st1_en      (st1_en),
    .st1_out     (st1_out),
    .st1_out_reg (st1_out_reg),
    .st1_ones_reg(st1_ones_reg),
    .st1_valid   (st1_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Builds q_m by walking the chain bit by bit, exactly as the encoding rules read.
  function automatic logic [8:0] model_qm(input logic [7:0] d);
    int   n1;
    logic xnor_mode;
    logic [8:0] q;
    n1 = $countones(d);
    xnor_mode = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xnor_mode ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = xnor_mode ? 1'b0 : 1'b1;
    return q;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_out_reg"}, {7'd0, st1_out_reg}, {7'd0, exp_out_reg});
    check({tag, "_ones"}, {12'd0, st1_ones_reg}, {12'd0, exp_ones});
    check({tag, "_valid"}, {15'd0, st1_valid}, {15'd0, exp_valid});
  endtask

  // Called about 1 time unit after a rising edge. It drives the inputs,
  // checks the combinational output, waits through one rising edge,
  // updates the reference, and then checks the registered outputs.
  task automatic cycle(input logic [7:0] d, input logic e, input string tag);
    logic [8:0] q;
    st1_in = d;
    st1_en = e;
    #1;
    q = model_qm(d);
    check({tag, "_comb"}, {7'd0, st1_out}, {7'd0, q});
    @(posedge clk);
    if (n_rst) begin
      exp_valid = e;
      if (e) begin
        exp_out_reg = q;
        exp_ones    = 4'($countones(q[7:0]));
      end
    end
    #1;
    check_regs(tag);
    $display("txn %s in=%02h en=%0b out=%03h out_reg=%03h ones=%0d valid=%0b",
             tag, d, e, st1_out, st1_out_reg, st1_ones_reg, st1_valid);
  endtask

  // Assert reset between clock edges. The registered outputs must clear
  // without any clock edge, and the combinational path must keep working.
  task automatic async_reset(input logic [7:0] d, input string tag);
    st1_in = d;
    #2;
    n_rst = 1'b0;
    #1;
    exp_out_reg = '0;
    exp_ones    = '0;
    exp_valid   = 1'b0;
    check_regs(tag);
    check({tag, "_comb"}, {7'd0, st1_out}, {7'd0, model_qm(d)});
    $display("txn %s async reset in=%02h out=%03h", tag, d, st1_out);
    @(posedge clk);
    #1;
    check_regs({tag, "_held"});
    n_rst = 1'b1;
  endtask

  initial begin
    logic [7:0] r_d;
    logic       r_e;
    checks = 0;
    failures = 0;
    n_rst = 1'b0;
    st1_in = 8'h00;
    st1_en = 1'b0;
    exp_out_reg = '0;
    exp_ones = '0;
    exp_valid = 1'b0;

    @(posedge clk);
    #1;
    check_regs("reset");

    // The spec lists exact expected words for these bytes.
    st1_in = 8'h00; #1; check("c00", {7'd0, st1_out}, 16'h0100);
    st1_in = 8'h11; #1; check("c11", {7'd0, st1_out}, 16'h010F);
    st1_in = 8'h75; #1; check("c75", {7'd0, st1_out}, 16'h0079);
    st1_in = 8'h0F; #1; check("c0F", {7'd0, st1_out}, 16'h0105);
    st1_in = 8'hF0; #1; check("cF0", {7'd0, st1_out}, 16'h00FA);
    st1_in = 8'hFF; #1; check("cFF", {7'd0, st1_out}, 16'h00FF);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Capture, then hold with valid dropping, then back-to-back captures.
    cycle(8'h75, 1'b1, "cap75");
    check("cap75_lit", {7'd0, st1_out_reg}, 16'h0079);
    check("cap75_ones", {12'd0, st1_ones_reg}, 16'd5);
    cycle(8'h11, 1'b0, "hold");
    check("hold_lit", {7'd0, st1_out_reg}, 16'h0079);
    cycle(8'h11, 1'b1, "strm11");
    check("strm11_lit", {7'd0, st1_out_reg}, 16'h010F);
    check("strm11_ones", {12'd0, st1_ones_reg}, 16'd4);
    cycle(8'h00, 1'b1, "strm00");
    check("strm00_lit", {7'd0, st1_out_reg}, 16'h0100);
    check("strm00_valid", {15'd0, st1_valid}, 16'd1);

    // Load nonzero outputs first, so that reset has something to clear.
    cycle(8'h0F, 1'b1, "pre_rst");
    async_reset(8'hA5, "arst");
    cycle(8'h3C, 1'b1, "post_rst");

    // Randomised traffic, with an occasional asynchronous reset mixed in.
    for (int k = 0; k < 300; k++) begin
      r_d = 8'($urandom_range(0, 255));
      r_e = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0)
        async_reset(r_d, "rnd_rst");
      else
        cycle(r_d, r_e, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
